// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch/data requesters (optional ARB_STARVE_GUARD_EN)
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   lat_cnt;
    logic               owner_dm;
    logic               we_q;
    logic               req_any;
    logic               grant_dm;
    logic               capture;

    assign req_any = if_req | dm_req;

    // Read data arrives on the last WAIT cycle; writes never touch the rdata registers.
    assign capture = (state == S_WAIT) && (lat_cnt == CNT_W'(1)) && !we_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;

    assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));
    // Once fetch has waited through STARVE_MAX data grants it wins the next arbitration.
    assign grant_dm   = dm_req && !(if_req && starve_hit);

    // Count data grants made while fetch is waiting; any fetch grant or fetch-idle arbitration clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE && req_any) begin
            if (grant_dm && if_req) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one access walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_any) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (lat_cnt == CNT_W'(1)) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the winner's operands at arbitration and run the latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            owner_dm  <= 1'b0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        owner_dm <= grant_dm;
                        if (grant_dm) begin
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            we_q      <= dm_we;
                        end else begin
                            mem_addr  <= if_addr;
                            we_q      <= 1'b0;
                        end
                    end
                end
                S_ISSUE: lat_cnt <= CNT_W'(MEM_LAT);
                S_WAIT:  lat_cnt <= lat_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Capture read data into the owning requester's register; held until its next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (capture) begin
            if (owner_dm) begin
                dm_rdata <= mem_rdata;
            end else begin
                if_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en = (state == S_ISSUE);
    assign mem_we = we_q & mem_en;
    assign busy   = (state != S_IDLE);
    assign if_ack = (state == S_RESP) && !owner_dm;
    assign dm_ack = (state == S_RESP) && owner_dm;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory device: read data valid MEM_LAT cycles after the mem_en cycle, garbage otherwise.
    logic [31:0] dev_mem [0:255];
    logic [31:0] pipe [0:MEM_LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) dev_mem[mem_addr[9:2]] = mem_wdata;
        pipe[0] <= mem_en ? dev_mem[mem_addr[9:2]] : 32'hBAD0_BAD0;
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[MEM_LAT-1];

    // Transaction-level model: a grant at cycle g gives mem_en at g+1, data at g+1+L,
    // ack at g+2+L and a free arbiter again at g+3+L.
    logic [31:0] ref_mem [0:255];
    int          cyc = 0;
    int          g = 0;
    bit          active = 0;
    bit          pristine = 1;
    bit          model_ok = 0;
    bit          g_dm, g_we, take_if;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] exp_if_rdata, exp_dm_rdata;
    int          starve = 0;

    always @(posedge clk) begin
        if (active && (cyc - g) == 1 && g_we) ref_mem[g_addr[9:2]] = g_wdata;
        if (rst) begin
            active = 0; pristine = 1; model_ok = 1; starve = 0;
            exp_if_rdata = '0; exp_dm_rdata = '0;
        end else if (model_ok) begin
            if (active && (cyc - g) == 1 + MEM_LAT && !g_we) begin
                if (g_dm) exp_dm_rdata = ref_mem[g_addr[9:2]];
                else      exp_if_rdata = ref_mem[g_addr[9:2]];
            end
            if ((!active || (cyc - g) >= 3 + MEM_LAT) && (if_req || dm_req)) begin
`ifdef ARB_STARVE_GUARD_EN
                take_if = if_req && (!dm_req || starve == STARVE_MAX);
`else
                take_if = if_req && !dm_req;
`endif
                if (take_if || !if_req) starve = 0;
                else starve = starve + 1;
                g = cyc; active = 1; pristine = 0;
                g_dm    = !take_if;
                g_we    = take_if ? 1'b0 : dm_we;
                g_addr  = take_if ? if_addr : dm_addr;
                g_wdata = dm_wdata;
            end
        end
        cyc = cyc + 1;
    end

    int dd;
    bit acc;
    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (model_ok) begin
            dd  = active ? (cyc - g) : -100;
            acc = (dd >= 1) && (dd <= 2 + MEM_LAT);
            chk("busy",     32'(busy),   32'(acc));
            chk("mem_en",   32'(mem_en), 32'(dd == 1));
            chk("mem_we",   32'(mem_we), 32'(dd == 1 && g_we));
            chk("if_ack",   32'(if_ack), 32'(dd == 2 + MEM_LAT && !g_dm));
            chk("dm_ack",   32'(dm_ack), 32'(dd == 2 + MEM_LAT && g_dm));
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("dm_rdata", dm_rdata, exp_dm_rdata);
            if (acc) chk("mem_addr", mem_addr, g_addr);
            if (acc && g_we) chk("mem_wdata", mem_wdata, g_wdata);
            if (pristine) begin
                chk("mem_addr_rst",  mem_addr,  32'h0);
                chk("mem_wdata_rst", mem_wdata, 32'h0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    bit ia, da, got_if;
    int n_dm, n_ack;

    initial begin
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
            ref_mem[i] = dev_mem[i];
        end
        dev_mem[8'h10] = 32'h2008_0005; ref_mem[8'h10] = 32'h2008_0005;
        dev_mem[8'h40] = 32'h1122_3344; ref_mem[8'h40] = 32'h1122_3344;

        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);

        // Single fetch of 0x40.
        step(1);
        if_req = 1'b1; if_addr = 32'h40;
        step(1); @(negedge clk);
        chk("t1_mem_en", 32'(mem_en), 32'h1);
        chk("t1_mem_addr", mem_addr, 32'h40);
        step(1); @(negedge clk);
        chk("t1_mem_en_once", 32'(mem_en), 32'h0);
        step(MEM_LAT); @(negedge clk);
        chk("t1_if_ack", 32'(if_ack), 32'h1);
        chk("t1_if_rdata", if_rdata, 32'h2008_0005);
        step(1); if_req = 1'b0; @(negedge clk);
        chk("t1_busy_low", 32'(busy), 32'h0);

        // Simultaneous requests: dm wins, fetch follows.
        step(1);
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        step(2 + MEM_LAT); @(negedge clk);
        chk("t2_dm_ack", 32'(dm_ack), 32'h1);
        chk("t2_if_ack_not_yet", 32'(if_ack), 32'h0);
        chk("t2_dm_rdata", dm_rdata, 32'h1122_3344);
        step(1); dm_req = 1'b0;
        step(1); @(negedge clk);
        chk("t2_if_mem_en", 32'(mem_en), 32'h1);
        chk("t2_if_mem_addr", mem_addr, 32'h40);
        step(1 + MEM_LAT); @(negedge clk);
        chk("t2_if_ack", 32'(if_ack), 32'h1);
        step(1); if_req = 1'b0;

        // Write then read back.
        step(1);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        step(1); @(negedge clk);
        chk("t3_mem_en", 32'(mem_en), 32'h1);
        chk("t3_mem_we", 32'(mem_we), 32'h1);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        step(1 + MEM_LAT); @(negedge clk);
        chk("t3_dm_ack", 32'(dm_ack), 32'h1);
        chk("t3_dm_rdata_kept", dm_rdata, 32'h1122_3344);
        step(1); dm_we = 1'b0;
        step(2 + MEM_LAT); @(negedge clk);
        chk("t3_rd_ack", 32'(dm_ack), 32'h1);
        chk("t3_rd_data", dm_rdata, 32'hDEAD_BEEF);
        step(1); dm_req = 1'b0;

        // Back-to-back data traffic with fetch held.
        step(1);
        if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        n_dm = 0; got_if = 0;
        for (int k = 0; k < 400 && !got_if && n_dm < 20; k++) begin
            @(negedge clk);
            da = dm_ack;
            if (dm_ack) n_dm++;
            if (if_ack) got_if = 1;
            step(1);
            if (da) dm_addr = dm_addr + 32'h4;
        end
        if_req = 1'b0; dm_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        chk("t4_if_granted", 32'(got_if), 32'h1);
        chk("t4_dm_before_if", 32'(n_dm), 32'(STARVE_MAX));
`else
        chk("t4_if_starved", 32'(got_if), 32'h0);
        chk("t4_dm_count", 32'(n_dm), 32'd20);
`endif
        step(MEM_LAT + 4);

        // Reset during WAIT aborts the access.
        if_req = 1'b1; if_addr = 32'h40;
        step(2);
        rst = 1'b1; if_req = 1'b0;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_mem_en", 32'(mem_en), 32'h0);
        chk("t5_mem_we", 32'(mem_we), 32'h0);
        chk("t5_mem_addr", mem_addr, 32'h0);
        chk("t5_mem_wdata", mem_wdata, 32'h0);
        chk("t5_if_rdata", if_rdata, 32'h0);
        chk("t5_dm_rdata", dm_rdata, 32'h0);
        chk("t5_acks", 32'({if_ack, dm_ack}), 32'h0);
        n_ack = 0;
        for (int k = 0; k < 10; k++) begin
            step(1); @(negedge clk);
            if (if_ack || dm_ack) n_ack++;
        end
        chk("t5_no_ack", 32'(n_ack), 32'h0);
        step(1);
        if_req = 1'b1; if_addr = 32'h40;
        step(2 + MEM_LAT); @(negedge clk);
        chk("t5_new_if_ack", 32'(if_ack), 32'h1);
        chk("t5_new_if_rdata", if_rdata, 32'h2008_0005);
        step(1); if_req = 1'b0;

        // Randomized traffic with occasional resets, checked by the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            ia = if_ack; da = dm_ack;
            step(1);
            rst = ($urandom_range(0, 299) == 0);
            if (!if_req || ia) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!dm_req || da) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                dm_wdata = $urandom;
            end
        end
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        step(MEM_LAT + 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
